// File: rtl/winit_pkg.sv
// Shared constants and FSM encoding for the PRNG weight-initialisation sequencer.
package winit_pkg;

    localparam int unsigned SHIFT_W         = 4;
    localparam int unsigned DEFAULT_W_WIDTH = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StFetch = ST_FETCH,
        StWait  = ST_WAIT,
        StWrite = ST_WRITE,
        StDone  = ST_DONE
    } winit_state_e;

endpackage

// File: rtl/winit_scale.sv
// Slices the top W_WIDTH bits of a PRNG sample as Q1.(W_WIDTH-1) and applies a
// saturated arithmetic right shift (truncating, no rounding).
module winit_scale
    import winit_pkg::*;
#(
    parameter int unsigned OUT_size = 32,
    parameter int unsigned W_WIDTH  = DEFAULT_W_WIDTH
) (
    input  logic [OUT_size-1:0] sample_i,
    input  logic [SHIFT_W-1:0]  shift_i,
    output logic [W_WIDTH-1:0]  scaled_o
);

    logic signed [W_WIDTH-1:0] slice;
    logic [SHIFT_W-1:0]        shift_eff;

    assign slice = sample_i[OUT_size-1 -: W_WIDTH];

    always_comb begin
        shift_eff = shift_i;
        if (int'(shift_i) >= int'(W_WIDTH)) begin
            shift_eff = SHIFT_W'(W_WIDTH - 1);
        end
    end

    assign scaled_o = slice >>> shift_eff;

    if (OUT_size > W_WIDTH) begin : g_low_bits
        // Low sample bits carry no weight information at this width.
        logic unused_low;
        assign unused_low = ^sample_i[OUT_size-W_WIDTH-1:0];
    end

endmodule

// File: rtl/prng_weight_init.sv
// Fills a weight RAM with scaled PRNG samples, one fetch per word, with a done pulse.
// Optional feature: WINIT_BIAS_ZERO_EN writes the last min(BIAS_WORDS, num_words) words as 0.
module prng_weight_init
    import winit_pkg::*;
#(
    parameter int unsigned OUT_size   = 32,
    parameter int unsigned W_WIDTH    = DEFAULT_W_WIDTH,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FETCH_LAT  = 1,
    parameter int unsigned BIAS_WORDS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic [SHIFT_W-1:0]    scale_shift,
    output logic                  busy,
    output logic                  done,
    output logic                  enablePRNG,
    output logic                  fetchNewSample,
    input  logic [OUT_size-1:0]   randomArray,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [W_WIDTH-1:0]    mem_wdata,
    input  logic                  mem_ready
);

    localparam int unsigned LAT_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;

    winit_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] nwords_q, nwords_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [W_WIDTH-1:0]    sample_q, sample_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fetch_q, fetch_d;
    logic                  we_q, we_d;
    logic [W_WIDTH-1:0]    scaled;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  bias_first;
    logic                  bias_next;

    winit_scale #(
        .OUT_size (OUT_size),
        .W_WIDTH  (W_WIDTH)
    ) u_scale (
        .sample_i (randomArray),
        .shift_i  (shift_q),
        .scaled_o (scaled)
    );

    assign addr_inc = addr_q + 1'b1;

`ifdef WINIT_BIAS_ZERO_EN
    // An address is a bias word when it lies within the last BIAS_WORDS of the fill.
    assign bias_first = int'(num_words) <= int'(BIAS_WORDS);
    assign bias_next  = (int'(nwords_q) - int'(addr_inc)) <= int'(BIAS_WORDS);
`else
    logic unused_bias_words;
    assign unused_bias_words = (BIAS_WORDS != 0);
    assign bias_first        = 1'b0;
    assign bias_next         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        nwords_d = nwords_q;
        shift_d  = shift_q;
        lat_d    = lat_q;
        sample_d = sample_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d   = '0;
                        nwords_d = num_words;
                        shift_d  = scale_shift;
                        if (bias_first) begin
                            sample_d = '0;
                            state_d  = StWrite;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            StFetch: begin
                lat_d   = LAT_W'(FETCH_LAT - 1);
                state_d = StWait;
            end
            StWait: begin
                if (lat_q == '0) begin
                    sample_d = scaled;
                    state_d  = StWrite;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    if (addr_q == nwords_q - 1'b1) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_inc;
                        if (bias_next) begin
                            sample_d = '0;
                            state_d  = StWrite;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        fetch_d = (state_d == StFetch);
        we_d    = (state_d == StWrite);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            nwords_q <= '0;
            shift_q  <= '0;
            lat_q    <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fetch_q  <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            nwords_q <= nwords_d;
            shift_q  <= shift_d;
            lat_q    <= lat_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fetch_q  <= fetch_d;
            we_q     <= we_d;
        end
    end

    assign busy           = busy_q;
    assign enablePRNG     = busy_q;
    assign done           = done_q;
    assign fetchNewSample = fetch_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = sample_q;

endmodule

// File: tb/tb_prng_weight_init.sv
// Randomised self-checking bench for prng_weight_init with a PRNG model and RAM monitor.
module tb_prng_weight_init;

    localparam int AW = 10;
    localparam int WW = 16;
    localparam int BIAS_WORDS = 4;
`ifdef WINIT_BIAS_ZERO_EN
    localparam bit BIAS_EN = 1'b1;
    localparam int PAD     = BIAS_WORDS;
`else
    localparam bit BIAS_EN = 1'b0;
    localparam int PAD     = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] num_words = '0;
    logic [3:0]    scale_shift = '0;
    logic          busy, done, enablePRNG, fetchNewSample, mem_we;
    logic [31:0]   randomArray = '0;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    prng_weight_init dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .num_words      (num_words),
        .scale_shift    (scale_shift),
        .busy           (busy),
        .done           (done),
        .enablePRNG     (enablePRNG),
        .fetchNewSample (fetchNewSample),
        .randomArray    (randomArray),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready)
    );

    always #5 clock = ~clock;

    // Logs filled by the PRNG model and the RAM-side monitor.
    int          cyc = 0;
    logic [31:0] force_q[$];
    logic [31:0] fetched[$];
    logic [AW-1:0] wr_addr[$];
    logic [WW-1:0] wr_data[$];
    logic [WW-1:0] exp_data[$];
    int  exp_fetches;
    int  fetch_cnt, done_cnt, done_cyc, start_cyc, first_wr_cyc, last_wr_cyc;
    int  stall_cycles, stable_viol;
    bit  prev_stall;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_data;
    bit  fetch_pend = 1'b0;
    bit  ready_rand = 1'b0;
    int  stall_addr = -1;
    int  stall_left = 0;

    always @(posedge clock) cyc++;

    // PRNG model: new sample one edge after the fetch request (FETCH_LAT = 1).
    always @(posedge clock) begin
        if (fetch_pend) begin
            logic [31:0] v;
            v = (force_q.size() > 0) ? force_q.pop_front() : $urandom();
            randomArray <= v;
            fetched.push_back(v);
            fetch_pend = 1'b0;
        end
    end

    always @(posedge clock) begin
        #1;
        if (stall_left > 0 && mem_we && int'(mem_addr) == stall_addr) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clock) begin
        if (fetchNewSample) begin
            fetch_pend = 1'b1;
            fetch_cnt++;
        end
        if (mem_we && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (wr_addr.size() == 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (mem_we && !mem_ready) stall_cycles++;
        if (prev_stall && (!mem_we || mem_addr !== prev_addr || mem_wdata !== prev_data))
            stable_viol++;
        prev_stall = mem_we && !mem_ready;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && !busy && reset) start_cyc = cyc;
    end

    function automatic logic [WW-1:0] ref_scale(input logic [31:0] s, input int sh);
        int v, d, q;
        if (sh > WW - 1) sh = WW - 1;
        v = int'(s[31:16]);
        if (v >= 32768) v -= 65536;
        d = 1 << sh;
        q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        return q[WW-1:0];
    endfunction

    // Expected write data for a fill of n words from the samples the PRNG handed out.
    task automatic build_expected(input int n, input int sh);
        int k = 0;
        int nb = (BIAS_EN) ? ((n < BIAS_WORDS) ? n : BIAS_WORDS) : 0;
        exp_data.delete();
        for (int a = 0; a < n; a++) begin
            if (a >= n - nb) begin
                exp_data.push_back('0);
            end else begin
                exp_data.push_back((k < fetched.size()) ? ref_scale(fetched[k], sh) : 'x);
                k++;
            end
        end
        exp_fetches = k;
    endtask

    task automatic clear_logs();
        fetched.delete();
        wr_addr.delete();
        wr_data.delete();
        fetch_cnt = 0; done_cnt = 0; stall_cycles = 0; stable_viol = 0;
        start_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    endtask

    task automatic start_fill(input int n, input int sh);
        @(posedge clock); #1;
        num_words = AW'(n); scale_shift = 4'(sh); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (enablePRNG !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", enablePRNG); end
        checks++; if (fetchNewSample !== 1'b0) begin failures++; $display("FAIL reset_fetch got=%b exp=0", fetchNewSample); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_scale_neg();
        bit ok;
        clear_logs();
        force_q.push_back(32'h8000_0000);
        start_fill(1 + PAD, 2);
        wait_done(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL neg_timeout got=no_done exp=done"); end
        checks++; if (wr_addr.size() !== 1 + PAD) begin failures++; $display("FAIL neg_count got=%0d exp=%0d", wr_addr.size(), 1 + PAD); end
        if (wr_addr.size() > 0) begin
            checks++; if (wr_addr[0] !== '0) begin failures++; $display("FAIL neg_addr got=%h exp=0", wr_addr[0]); end
            checks++; if (wr_data[0] !== 16'hE000) begin failures++; $display("FAIL neg_data got=%h exp=e000", wr_data[0]); end
        end
        checks++; if (first_wr_cyc !== start_cyc + 3) begin failures++; $display("FAIL neg_first_write got=%0d exp=%0d", first_wr_cyc, start_cyc + 3); end
        checks++; if (done_cyc !== last_wr_cyc + 1) begin failures++; $display("FAIL neg_done_cycle got=%0d exp=%0d", done_cyc, last_wr_cyc + 1); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL neg_done_pulses got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_scale_pos();
        int shifts[3] = '{3, 15, 9};
        logic [WW-1:0] want[3] = '{16'h0FFF, 16'h0000, 16'h003F};
        bit ok;
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            force_q.push_back(32'h7FFF_FFFF);
            start_fill(1 + PAD, shifts[i]);
            wait_done(200, ok);
            checks++; if (!ok || wr_data.size() == 0) begin failures++; $display("FAIL pos_shift%0d_nowrite got=%0d exp=%0d", shifts[i], wr_data.size(), 1 + PAD); end
            else begin
                checks++; if (wr_data[0] !== want[i]) begin failures++; $display("FAIL pos_shift%0d got=%h exp=%h", shifts[i], wr_data[0], want[i]); end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(1, 8) + PAD;
            int sh = $urandom_range(0, 15);
            clear_logs();
            ready_rand = 1'b1;
            start_fill(n, sh);
            wait_done(400, ok);
            ready_rand = 1'b0;
            build_expected(n, sh);
            checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout got=no_done exp=done", it); end
            checks++; if (wr_addr.size() !== n) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wr_addr.size(), n); end
            checks++; if (fetch_cnt !== exp_fetches) begin failures++; $display("FAIL rand%0d_fetches got=%0d exp=%0d", it, fetch_cnt, exp_fetches); end
            for (int a = 0; a < wr_addr.size() && a < n; a++) begin
                checks++;
                if (wr_addr[a] !== AW'(a) || wr_data[a] !== exp_data[a]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d got=%h/%h exp=%h/%h", it, a, wr_addr[a], wr_data[a], AW'(a), exp_data[a]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        bit ok;
        clear_logs();
        stall_addr = 1;
        stall_left = 5;
        start_fill(4, $urandom_range(0, 15));
        wait_done(200, ok);
        build_expected(4, int'(dut.shift_q));
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
        checks++; if (stall_cycles !== 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", stall_cycles); end
        checks++; if (stable_viol !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stable_viol); end
        checks++; if (wr_addr.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", wr_addr.size()); end
        checks++; if (fetch_cnt !== exp_fetches) begin failures++; $display("FAIL bp_fetches got=%0d exp=%0d", fetch_cnt, exp_fetches); end
        for (int a = 0; a < wr_addr.size() && a < 4; a++) begin
            checks++;
            if (wr_addr[a] !== AW'(a) || wr_data[a] !== exp_data[a]) begin
                failures++;
                $display("FAIL bp_word%0d got=%h/%h exp=%h/%h", a, wr_addr[a], wr_data[a], AW'(a), exp_data[a]);
            end
        end
        stall_addr = -1;
    endtask

    task automatic test_degenerate();
        bit ok;
        int sh;
        clear_logs();
        start_fill(0, 5);
        wait_done(20, ok);
        checks++; if (done_cyc !== start_cyc + 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + 1); end
        checks++; if (wr_addr.size() !== 0 || fetch_cnt !== 0) begin failures++; $display("FAIL zero_activity got=%0d/%0d exp=0/0", wr_addr.size(), fetch_cnt); end

        clear_logs();
        sh = $urandom_range(0, 15);
        start_fill(16, sh);
        ok = 1'b0;
        // Foreign start pulses with different parameters while the fill runs.
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
            start = (i % 7 == 3);
            num_words = 3;
            scale_shift = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        build_expected(16, sh);
        checks++; if (!ok) begin failures++; $display("FAIL fill16_timeout got=no_done exp=done"); end
        checks++; if (wr_addr.size() !== 16 || done_cnt !== 1) begin failures++; $display("FAIL fill16_count got=%0d/%0d exp=16/1", wr_addr.size(), done_cnt); end
        for (int a = 0; a < wr_addr.size() && a < 16; a++) begin
            checks++;
            if (wr_addr[a] !== AW'(a) || wr_data[a] !== exp_data[a]) begin
                failures++;
                $display("FAIL fill16_word%0d got=%h/%h exp=%h/%h", a, wr_addr[a], wr_data[a], AW'(a), exp_data[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int sh = $urandom_range(0, 15);
        clear_logs();
        start_fill(8 + PAD, sh);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            if (fetch_cnt == 5) begin
                ok = 1'b1;
                break;
            end
        end
        reset = 1'b0;
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL mid_reach_wait got=%0d exp=5", fetch_cnt); end
        checks++;
        if ({busy, done, enablePRNG, fetchNewSample, mem_we} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b%b%b%b%b/%h/%h exp=0", busy, done, enablePRNG,
                     fetchNewSample, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        fetch_pend = 1'b0;
        clear_logs();
        start_fill(2 + PAD, sh);
        wait_done(200, ok);
        build_expected(2 + PAD, sh);
        checks++; if (!ok || wr_addr.size() !== 2 + PAD) begin failures++; $display("FAIL mid_refill_count got=%0d exp=%0d", wr_addr.size(), 2 + PAD); end
        for (int a = 0; a < wr_addr.size() && a < 2 + PAD; a++) begin
            checks++;
            if (wr_addr[a] !== AW'(a) || wr_data[a] !== exp_data[a]) begin
                failures++;
                $display("FAIL mid_refill_word%0d got=%h/%h exp=%h/%h", a, wr_addr[a], wr_data[a], AW'(a), exp_data[a]);
            end
        end
    endtask

`ifdef WINIT_BIAS_ZERO_EN
    task automatic test_bias();
        int ns[2] = '{6, 3};
        int nf[2] = '{2, 0};
        bit ok;
        for (int t = 0; t < 2; t++) begin
            clear_logs();
            start_fill(ns[t], 0);
            wait_done(200, ok);
            checks++; if (!ok || wr_addr.size() !== ns[t]) begin failures++; $display("FAIL bias%0d_count got=%0d exp=%0d", ns[t], wr_addr.size(), ns[t]); end
            checks++; if (fetch_cnt !== nf[t]) begin failures++; $display("FAIL bias%0d_fetches got=%0d exp=%0d", ns[t], fetch_cnt, nf[t]); end
            for (int a = 0; a < wr_addr.size() && a < ns[t]; a++) begin
                checks++;
                if (wr_addr[a] !== AW'(a) || (a >= nf[t] && wr_data[a] !== '0) ||
                    (a < nf[t] && wr_data[a] !== ref_scale(fetched[a], 0))) begin
                    failures++;
                    $display("FAIL bias%0d_word%0d got=%h/%h", ns[t], a, wr_addr[a], wr_data[a]);
                end
            end
        end
    endtask
`endif

    initial begin
        clear_logs();
        test_reset();
        test_scale_neg();
        test_scale_pos();
        test_random();
        test_back_pressure();
        test_degenerate();
        test_reset_mid();
`ifdef WINIT_BIAS_ZERO_EN
        test_bias();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
